// File: rtl/jtag_tap_pkg.sv
// Shared definitions for the JTAG TAP responder.
//   tap_state_e : 16 TAP controller states, encoded per the IEEE 1149.1 table
//                 so TAP_STATE matches what external debug tools expect.
//   OP_*        : instruction opcodes for the default 4-bit IR.
//   IR_CAPTURE  : fixed low bits loaded into the IR shift register on Capture-IR.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0,
    EXIT1_DR = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8,
    EXIT1_IR = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  localparam logic [3:0] OP_IDCODE = 4'b1110;
  localparam logic [3:0] OP_USER   = 4'b1000;
  localparam logic [3:0] OP_BYPASS = 4'b1111;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_pin_sync.sv
// Brings the asynchronous JTAG pins into the CLK domain.
//   CLK, RST          : system clock, synchronous active-high reset
//   TCK/TMS/TDI/nTRST : raw JTAG pins
//   tck_rise/tck_fall : one-CLK strobes on synchronized TCK edges
//   tms_s/tdi_s       : TMS/TDI from the same sync stage as TCK
//   trst_s            : active-high TAP reset from synchronized nTRST
module jtag_pin_sync (
  input  logic CLK,
  input  logic RST,
  input  logic TCK,
  input  logic TMS,
  input  logic TDI,
  input  logic nTRST,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s,
  output logic trst_s
);

  logic [1:0] tck_sy;
  logic [1:0] tms_sy;
  logic [1:0] tdi_sy;
  logic [1:0] trst_sy;
  logic       tck_hist;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tck_sy   <= '0;
      tms_sy   <= '0;
      tdi_sy   <= '0;
      trst_sy  <= '0;
      tck_hist <= 1'b0;
    end else begin
      trst_sy <= {trst_sy[0], nTRST};
      // The nTRST chain itself is never cleared by nTRST, otherwise it would
      // latch itself low forever.
      if (!trst_sy[1]) begin
        tck_sy   <= '0;
        tms_sy   <= '0;
        tdi_sy   <= '0;
        tck_hist <= 1'b0;
      end else begin
        tck_sy   <= {tck_sy[0], TCK};
        tms_sy   <= {tms_sy[0], TMS};
        tdi_sy   <= {tdi_sy[0], TDI};
        tck_hist <= tck_sy[1];
      end
    end
  end

  always_comb begin
    trst_s   = ~trst_sy[1];
    tck_rise = tck_sy[1] & ~tck_hist & ~trst_s;
    tck_fall = ~tck_sy[1] & tck_hist & ~trst_s;
    tms_s    = tms_sy[1];
    tdi_s    = tdi_sy[1];
  end

endmodule

// File: rtl/jtag_tap_responder.sv
// Target-side IEEE 1149.1 TAP: oversampled TAP controller with IR and
// IDCODE / BYPASS / USER data registers.
//   CLK, RST                : system clock, synchronous active-high reset
//   TCK, TMS, TDI, nTRST    : asynchronous JTAG pins
//   TDO, TDO_OE             : serial out, enabled only in Shift-IR/Shift-DR
//   USER_DIN                : captured into USER on Capture-DR
//   USER_DOUT, USER_UPDATE  : USER value and 1-CLK strobe on Update-DR
//   TAP_STATE, IR_VALUE     : current TAP state and instruction
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int          IR_LEN     = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1BB0_0001,
  parameter int          USER_LEN   = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TCK,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                nTRST,
  output logic                TDO,
  output logic                TDO_OE,
  input  logic [USER_LEN-1:0] USER_DIN,
  output logic [USER_LEN-1:0] USER_DOUT,
  output logic                USER_UPDATE,
  output logic [3:0]          TAP_STATE,
  output logic [IR_LEN-1:0]   IR_VALUE
);

  // Opcodes generalised to IR_LEN: IDCODE all-ones but bit 0, USER MSB only.
  localparam logic [IR_LEN-1:0] IR_IDCODE = (IR_LEN == 4) ? IR_LEN'(OP_IDCODE) : ~IR_LEN'(1);
  localparam logic [IR_LEN-1:0] IR_USER   = (IR_LEN == 4) ? IR_LEN'(OP_USER)
                                                          : IR_LEN'(1) << (IR_LEN - 1);
  localparam logic [IR_LEN-1:0] IR_CAP    = IR_LEN'(IR_CAPTURE);

  logic tck_rise;
  logic tck_fall;
  logic tms_s;
  logic tdi_s;
  logic trst_s;
  logic rst_all;

  jtag_pin_sync u_sync (
    .CLK      (CLK),
    .RST      (RST),
    .TCK      (TCK),
    .TMS      (TMS),
    .TDI      (TDI),
    .nTRST    (nTRST),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s),
    .trst_s   (trst_s)
  );

  assign rst_all = RST | trst_s;

  tap_state_e state_q;
  tap_state_e state_d;
  tap_state_e tap_next;

  always_ff @(posedge CLK) begin
    if (rst_all) state_q <= TLR;
    else         state_q <= state_d;
  end

  always_comb begin
    tap_next = state_q;
    case (state_q)
      TLR:      tap_next = tms_s ? TLR      : RTI;
      RTI:      tap_next = tms_s ? SEL_DR   : RTI;
      SEL_DR:   tap_next = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: tap_next = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_next = tms_s ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: tap_next = tms_s ? UPD_DR   : SHIFT_DR;
      UPD_DR:   tap_next = tms_s ? SEL_DR   : RTI;
      SEL_IR:   tap_next = tms_s ? TLR      : CAP_IR;
      CAP_IR:   tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: tap_next = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_next = tms_s ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: tap_next = tms_s ? UPD_IR   : SHIFT_IR;
      UPD_IR:   tap_next = tms_s ? SEL_DR   : RTI;
      default:  tap_next = TLR;
    endcase
    state_d = tck_rise ? tap_next : state_q;
  end

  logic [IR_LEN-1:0]   ir_shift;
  logic [31:0]         id_shift;
  logic [USER_LEN-1:0] user_shift;
  logic                byp_shift;
  logic                sel_idcode;
  logic                sel_user;
  logic                dr_lsb;

  always_comb begin
    sel_idcode = (IR_VALUE == IR_IDCODE);
    sel_user   = (IR_VALUE == IR_USER);
    if (sel_idcode)    dr_lsb = id_shift[0];
    else if (sel_user) dr_lsb = user_shift[0];
    else               dr_lsb = byp_shift;
  end

  // Actions key off state_q, i.e. the state held before this rising edge.
  always_ff @(posedge CLK) begin
    if (rst_all) begin
      IR_VALUE    <= IR_IDCODE;
      ir_shift    <= '0;
      id_shift    <= '0;
      user_shift  <= '0;
      byp_shift   <= 1'b0;
      USER_DOUT   <= '0;
      USER_UPDATE <= 1'b0;
      TDO         <= 1'b0;
    end else begin
      USER_UPDATE <= 1'b0;
      if (tck_rise) begin
        case (state_q)
          CAP_IR:   ir_shift <= IR_CAP;
          SHIFT_IR: ir_shift <= IR_LEN'({tdi_s, ir_shift} >> 1);
          UPD_IR:   IR_VALUE <= ir_shift;
          CAP_DR: begin
            if (sel_idcode)    id_shift   <= IDCODE_VAL;
            else if (sel_user) user_shift <= USER_DIN;
            else               byp_shift  <= 1'b0;
          end
          SHIFT_DR: begin
            if (sel_idcode)    id_shift   <= {tdi_s, id_shift[31:1]};
            else if (sel_user) user_shift <= USER_LEN'({tdi_s, user_shift} >> 1);
            else               byp_shift  <= tdi_s;
          end
          UPD_DR: begin
            if (sel_user) begin
              USER_DOUT   <= user_shift;
              USER_UPDATE <= 1'b1;
            end
          end
          default: ;
        endcase
        if (tap_next == TLR) IR_VALUE <= IR_IDCODE;
      end
      if (tck_fall) begin
        if (state_q == SHIFT_IR)      TDO <= ir_shift[0];
        else if (state_q == SHIFT_DR) TDO <= dr_lsb;
      end
    end
  end

  assign TDO_OE    = (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
  assign TAP_STATE = state_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Scoreboard bench for jtag_tap_responder: scan tasks push expected TDO bits,
// a monitor pops them after each TCK fall while TDO_OE is high.
module tb_jtag_tap_responder;

  localparam int          IR_LEN   = 4;
  localparam int          USER_LEN = 8;
  localparam logic [31:0] IDV      = 32'h1BB0_0001;
  localparam int          HALF     = 6;

  localparam logic [3:0] C_IDCODE = 4'b1110;
  localparam logic [3:0] C_USER   = 4'b1000;
  localparam logic [3:0] C_BYPASS = 4'b1111;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic                TCK = 1'b0;
  logic                TMS = 1'b0;
  logic                TDI = 1'b0;
  logic                nTRST = 1'b1;
  logic                TDO;
  logic                TDO_OE;
  logic [USER_LEN-1:0] USER_DIN = '0;
  logic [USER_LEN-1:0] USER_DOUT;
  logic                USER_UPDATE;
  logic [3:0]          TAP_STATE;
  logic [IR_LEN-1:0]   IR_VALUE;

  jtag_tap_responder #(
    .IR_LEN     (IR_LEN),
    .IDCODE_VAL (IDV),
    .USER_LEN   (USER_LEN)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .TCK         (TCK),
    .TMS         (TMS),
    .TDI         (TDI),
    .nTRST       (nTRST),
    .TDO         (TDO),
    .TDO_OE      (TDO_OE),
    .USER_DIN    (USER_DIN),
    .USER_DOUT   (USER_DOUT),
    .USER_UPDATE (USER_UPDATE),
    .TAP_STATE   (TAP_STATE),
    .IR_VALUE    (IR_VALUE)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   failures = 0;
  logic q[$];
  int   upd_cycles = 0;
  int   exp_upd = 0;

  logic [IR_LEN-1:0]   m_ir = C_IDCODE;
  logic [USER_LEN-1:0] m_user = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // TDO monitor: one sample per TCK fall, well after the synchronizer latency.
  initial forever begin
    @(negedge TCK);
    repeat (5) @(negedge CLK);
    if (TDO_OE === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL tdo_unexpected actual_oe=%0b expected_oe=0", TDO_OE);
      end else begin
        logic e;
        e = q.pop_front();
        if (TDO !== e) begin
          failures++;
          $display("FAIL tdo_bit actual=%0b expected=%0b", TDO, e);
        end
      end
    end
  end

  always @(negedge CLK) if (USER_UPDATE === 1'b1) upd_cycles++;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic tck(input logic tms, input logic tdi, input bit expect_out, input logic eb);
    @(negedge CLK);
    TMS = tms;
    TDI = tdi;
    repeat (HALF - 1) @(negedge CLK);
    TCK = 1'b1;
    repeat (HALF) @(negedge CLK);
    if (expect_out) q.push_back(eb);
    TCK = 1'b0;
    repeat (HALF) @(negedge CLK);
  endtask

  // Selected data register length and capture value for the model instruction.
  task automatic model_dr(output int len, output logic [63:0] cap);
    if (m_ir == C_IDCODE) begin
      len = 32; cap = 64'(IDV);
    end else if (m_ir == C_USER) begin
      len = USER_LEN; cap = 64'(USER_DIN);
    end else begin
      len = 1; cap = '0;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, TAP_STATE, 4'hC);
    check({tag, "_ir"}, IR_VALUE, m_ir);
    check({tag, "_user_dout"}, USER_DOUT, m_user);
    check({tag, "_update_cycles"}, upd_cycles, exp_upd);
    check({tag, "_tdo_drained"}, q.size(), 0);
  endtask

  // Scan from RTI back to RTI. The register is modelled as a bit stream:
  // captured bits followed by TDI bits; TDO shows the head, the register keeps
  // the L bits after the first n.
  task automatic scan(input bit is_ir, input int n, input logic [63:0] din, input int pause_at);
    int           len;
    logic [63:0]  cap;
    logic [127:0] s;
    logic [63:0]  fin;
    if (is_ir) begin
      len = IR_LEN; cap = 64'd1;
    end else begin
      model_dr(len, cap);
    end
    s = '0;
    for (int i = 0; i < len; i++) s[i] = cap[i];
    for (int i = 0; i < n; i++) s[len + i] = din[i];
    tck(1'b1, 1'b0, 1'b0, 1'b0);
    if (is_ir) tck(1'b1, 1'b0, 1'b0, 1'b0);
    tck(1'b0, 1'b0, 1'b0, 1'b0);
    tck(1'b0, 1'b0, 1'b1, s[0]);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        tck(1'b1, din[i], 1'b0, 1'b0);
      end else if (pause_at != 0 && i == pause_at - 1) begin
        tck(1'b1, din[i], 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) tck(1'b0, 1'b0, 1'b0, 1'b0);
        tck(1'b1, 1'b0, 1'b0, 1'b0);
        tck(1'b0, 1'b0, 1'b1, s[i + 1]);
      end else begin
        tck(1'b0, din[i], 1'b1, s[i + 1]);
      end
    end
    tck(1'b1, 1'b0, 1'b0, 1'b0);
    tck(1'b0, 1'b0, 1'b0, 1'b0);
    fin = '0;
    for (int i = 0; i < len; i++) fin[i] = s[n + i];
    if (is_ir) begin
      m_ir = fin[IR_LEN-1:0];
    end else if (m_ir == C_USER) begin
      m_user = fin[USER_LEN-1:0];
      exp_upd++;
    end
  endtask

  task automatic abort_shift(input bit use_trst);
    int          len;
    logic [63:0] cap;
    USER_DIN = USER_LEN'($urandom);
    model_dr(len, cap);
    tck(1'b1, 1'b0, 1'b0, 1'b0);
    tck(1'b0, 1'b0, 1'b0, 1'b0);
    tck(1'b0, 1'b0, 1'b1, cap[0]);
    for (int i = 0; i < 3; i++) tck(1'b0, 1'($urandom), 1'b1, cap[i + 1]);
    @(negedge CLK);
    if (use_trst) begin
      nTRST = 1'b0;
      repeat (4) @(negedge CLK);
      nTRST = 1'b1;
    end else begin
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
    end
    repeat (8) @(negedge CLK);
    m_ir = C_IDCODE;
    m_user = '0;
    check(use_trst ? "trst_state" : "rst_state", TAP_STATE, 4'hF);
    check(use_trst ? "trst_ir" : "rst_ir", IR_VALUE, C_IDCODE);
    check(use_trst ? "trst_user_dout" : "rst_user_dout", USER_DOUT, '0);
    check(use_trst ? "trst_no_update" : "rst_no_update", upd_cycles, exp_upd);
    check(use_trst ? "trst_oe" : "rst_oe", TDO_OE, 1'b0);
    check(use_trst ? "trst_tdo" : "rst_tdo", TDO, 1'b0);
    tck(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check("reset_state", TAP_STATE, 4'hF);
    check("reset_ir", IR_VALUE, C_IDCODE);
    check("reset_tdo", TDO, 1'b0);
    check("reset_oe", TDO_OE, 1'b0);
    check("reset_user_dout", USER_DOUT, '0);
    check("reset_update", USER_UPDATE, 1'b0);

    tck(1'b0, 1'b0, 1'b0, 1'b0);
    check("tlr_to_rti", TAP_STATE, 4'hC);

    scan(1'b0, 32, {$urandom, $urandom}, 0);
    check_idle("idcode");

    scan(1'b1, IR_LEN, 64'(4'b1000), 0);
    check_idle("ir_user");

    USER_DIN = 8'h5A;
    scan(1'b0, USER_LEN, 64'(8'hC3), 0);
    check_idle("user_c3");
    check("user_c3_value", USER_DOUT, 8'hC3);

    scan(1'b1, IR_LEN, 64'(C_BYPASS), 0);
    scan(1'b0, 4, 64'(4'b1101), 0);
    check_idle("bypass_ones");

    scan(1'b1, IR_LEN, 64'(4'b0101), 0);
    scan(1'b0, 4, 64'(4'b1101), 0);
    check_idle("bypass_undef");

    scan(1'b1, IR_LEN, 64'(C_USER), 0);
    abort_shift(1'b1);
    scan(1'b1, IR_LEN, 64'(C_USER), 0);
    abort_shift(1'b0);

    scan(1'b1, IR_LEN, 64'(C_USER), 0);
    tck(1'b1, 1'b0, 1'b0, 1'b0);
    tck(1'b1, 1'b0, 1'b0, 1'b0);
    tck(1'b0, 1'b0, 1'b0, 1'b0);
    tck(1'b1, 1'b0, 1'b0, 1'b0);
    tck(1'b0, 1'b0, 1'b0, 1'b0);
    check("pause_ir_state", TAP_STATE, 4'hB);
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, 1'b0, 1'b0);
    m_ir = C_IDCODE;
    check("five_tms_state", TAP_STATE, 4'hF);
    check("five_tms_ir", IR_VALUE, C_IDCODE);
    tck(1'b0, 1'b0, 1'b0, 1'b0);

    scan(1'b1, IR_LEN, 64'(C_USER), 0);
    USER_DIN = USER_LEN'($urandom);
    scan(1'b0, USER_LEN, 64'($urandom), 3);
    check_idle("pause_dr");

    for (int it = 0; it < 12; it++) begin
      logic [3:0] op;
      case ($urandom_range(0, 3))
        0:       op = C_IDCODE;
        1:       op = C_USER;
        2:       op = C_BYPASS;
        default: op = 4'($urandom);
      endcase
      scan(1'b1, IR_LEN, 64'(op), 0);
      USER_DIN = USER_LEN'($urandom);
      scan(1'b0, int'($urandom_range(1, 40)), {$urandom, $urandom}, 0);
      check_idle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
